// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: RV32I funct3 codes, FSM encoding
// and request-classification helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Error responses are raised straight from IDLE so the unit is ready again
  // in the response cycle; ERR only appears as a recovery target.
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_WAIT = 2'd1;
  localparam logic [1:0] WR      = 2'd2;
  localparam logic [1:0] ERR     = 2'd3;

  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we)
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    if ((f3 == F3_H) || (f3 == F3_HU))
      return a[0];
    if (f3 == F3_W)
      return a != 2'b00;
    return 1'b0;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data path: load extract/extend and byte/half store merge.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_rdata,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load_data,
  output logic [31:0] o_store_data
);

  always_comb begin
    o_load_data = i_rdata;
    case (i_funct3)
      F3_B:    o_load_data = {{24{i_rdata[7]}}, i_rdata[7:0]};
      F3_BU:   o_load_data = {24'd0, i_rdata[7:0]};
      F3_H:    o_load_data = {{16{i_rdata[15]}}, i_rdata[15:0]};
      F3_HU:   o_load_data = {16'd0, i_rdata[15:0]};
      default: o_load_data = i_rdata;
    endcase
  end

  // Memory always writes a full word, so narrow stores keep the bytes just read.
  always_comb begin
    o_store_data = i_wdata;
    case (i_funct3)
      F3_B:    o_store_data = {i_rdata[31:8], i_wdata[7:0]};
      F3_H:    o_store_data = {i_rdata[31:16], i_wdata[15:0]};
      default: o_store_data = i_wdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// RV32I load/store unit with read-modify-write for SB/SH.
// Define LSU_MISALIGN_TRAP_EN to turn misaligned accesses into error responses.
module lsu
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_re,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out,
  input  logic        o_mem_re
);

  logic [1:0]  r_state;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [31:0] r_wdata;
  logic        r_req_ready;
  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;
  logic        r_resp_err;
  logic        r_mem_re;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_data_in;

  logic        w_accept;
  logic        w_err;
  logic [31:0] w_load_data;
  logic [31:0] w_store_data;

  assign w_accept = req_valid & r_req_ready;

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_err = !f3_legal(req_we, req_funct3) || misaligned(req_funct3, req_addr[1:0]);
`else
  assign w_err = !f3_legal(req_we, req_funct3);
`endif

  lsu_align u_align (
    .i_funct3     (r_funct3),
    .i_rdata      (mem_data_out),
    .i_wdata      (r_wdata),
    .o_load_data  (w_load_data),
    .o_store_data (w_store_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_we          <= 1'b0;
      r_funct3      <= 3'd0;
      r_wdata       <= 32'd0;
      r_req_ready   <= 1'b1;
      r_resp_valid  <= 1'b0;
      r_resp_rdata  <= 32'd0;
      r_resp_err    <= 1'b0;
      r_mem_re      <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= 32'd0;
      r_mem_data_in <= 32'd0;
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= 32'd0;
      r_mem_re     <= 1'b0;
      r_mem_we     <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_wdata  <= req_wdata;
            if (w_err) begin
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
            end else if (req_we && (req_funct3 == F3_W)) begin
              r_mem_we      <= 1'b1;
              r_mem_addr    <= req_addr;
              r_mem_data_in <= req_wdata;
              r_state       <= WR;
              r_req_ready   <= 1'b0;
            end else begin
              r_mem_re    <= 1'b1;
              r_mem_addr  <= req_addr;
              r_state     <= RD_WAIT;
              r_req_ready <= 1'b0;
            end
          end
        end
        RD_WAIT: begin
          if (o_mem_re) begin
            if (!r_we) begin
              r_resp_valid <= 1'b1;
              r_resp_rdata <= w_load_data;
              r_state      <= IDLE;
              r_req_ready  <= 1'b1;
            end else begin
              r_mem_we      <= 1'b1;
              r_mem_data_in <= w_store_data;
              r_state       <= WR;
            end
          end
        end
        WR: begin
          r_resp_valid <= 1'b1;
          r_state      <= IDLE;
          r_req_ready  <= 1'b1;
        end
        ERR: begin
          r_state     <= IDLE;
          r_req_ready <= 1'b1;
        end
        default: begin
          r_state     <= IDLE;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  // Held low while reset is asserted; the unit is idle the moment it releases.
  assign req_ready   = r_req_ready & rst_n;
  assign resp_valid  = r_resp_valid;
  assign resp_rdata  = r_resp_rdata;
  assign resp_err    = r_resp_err;
  assign mem_re      = r_mem_re;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_data_in = r_mem_data_in;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed test-plan steps then random traffic
// against a byte-array reference model.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;
  logic        mem_rvalid;

  int checks = 0;
  int errors = 0;
  int txn_no = 0;

  logic [31:0] last_rdata;
  logic        last_err;
  logic [31:0] last_we_data;

  logic [7:0] mem     [0:1023];
  logic [7:0] ref_mem [0:1023];

  lsu dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_re       (mem_re),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out),
    .o_mem_re     (mem_rvalid)
  );

  always #5 clk = ~clk;

  // Byte-addressed memory, no reset, read data one cycle after the strobe.
  always @(posedge clk) begin
    mem_rvalid <= mem_re;
    if (mem_re)
      mem_data_out <= {mem[mem_addr[9:0] + 10'd3], mem[mem_addr[9:0] + 10'd2],
                       mem[mem_addr[9:0] + 10'd1], mem[mem_addr[9:0]]};
    else
      mem_data_out <= $urandom;
    if (mem_we) begin
      mem[mem_addr[9:0]]         <= mem_data_in[7:0];
      mem[mem_addr[9:0] + 10'd1] <= mem_data_in[15:8];
      mem[mem_addr[9:0] + 10'd2] <= mem_data_in[23:16];
      mem[mem_addr[9:0] + 10'd3] <= mem_data_in[31:24];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [9:0] b = a[9:0];
    return {ref_mem[b + 10'd3], ref_mem[b + 10'd2], ref_mem[b + 10'd1], ref_mem[b]};
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] w = ref_word(a);
    logic [31:0] lo8 = {24'd0, w[7:0]};
    logic [31:0] lo16 = {16'd0, w[15:0]};
    case (f3)
      3'd0:    return (lo8 >= 32'd128) ? lo8 - 32'd256 : lo8;
      3'd1:    return (lo16 >= 32'd32768) ? lo16 - 32'd65536 : lo16;
      3'd4:    return lo8;
      3'd5:    return lo16;
      default: return w;
    endcase
  endfunction

  // Caller must be at a falling edge; returns at the falling edge of the response cycle.
  task automatic do_req(input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd);
    int size, exp_lat, exp_re_cyc, exp_we_cyc, cyc;
    int re_cnt, we_cnt, overlap, re_cyc, we_cyc, rv_cyc;
    logic legal, err, got;
    logic [31:0] exp_rdata, exp_wdata, re_addr, we_addr, we_data, rd, old_word;

    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    err   = !legal;
`ifdef LSU_MISALIGN_TRAP_EN
    if ((addr % size) != 0) err = 1'b1;
`endif
    exp_rdata = 32'd0;
    exp_wdata = 32'd0;
    exp_re_cyc = 0;
    exp_we_cyc = 0;
    if (err) begin
      exp_lat = 1;
    end else if (!we) begin
      exp_lat = 3; exp_re_cyc = 1;
      exp_rdata = ref_load(f3, addr);
    end else begin
      old_word = ref_word(addr);
      if (size == 4) begin
        exp_lat = 2; exp_we_cyc = 1; exp_wdata = wd;
      end else begin
        exp_lat = 4; exp_re_cyc = 1; exp_we_cyc = 3;
        exp_wdata = (size == 1) ? {old_word[31:8], wd[7:0]} : {old_word[31:16], wd[15:0]};
      end
      for (int i = 0; i < size; i++)
        ref_mem[10'(addr + 32'(i))] = wd[8*i +: 8];
    end

    chk("ready_at_accept", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0; req_we = $urandom; req_funct3 = $urandom;
    req_addr = $urandom; req_wdata = $urandom;

    cyc = 1; got = 0; re_cnt = 0; we_cnt = 0; overlap = 0;
    re_cyc = 0; we_cyc = 0; rv_cyc = 0; re_addr = 0; we_addr = 0; we_data = 0; rd = 0;
    while (cyc <= 8 && !got) begin
      if (mem_re && mem_we) overlap++;
      if (mem_re) begin re_cnt++; re_cyc = cyc; re_addr = mem_addr; end
      if (mem_we) begin we_cnt++; we_cyc = cyc; we_addr = mem_addr; we_data = mem_data_in; end
      if (resp_valid) begin
        got = 1; rv_cyc = cyc; rd = resp_rdata; last_err = resp_err;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end

    chk("resp_latency", 32'(rv_cyc), 32'(exp_lat));
    chk("resp_err", {31'd0, last_err}, {31'd0, err});
    chk("resp_rdata", rd, exp_rdata);
    chk("mem_re_count", 32'(re_cnt), (exp_re_cyc != 0) ? 32'd1 : 32'd0);
    chk("mem_we_count", 32'(we_cnt), (exp_we_cyc != 0) ? 32'd1 : 32'd0);
    chk("re_we_overlap", 32'(overlap), 32'd0);
    if (exp_re_cyc != 0) begin
      chk("mem_re_cycle", 32'(re_cyc), 32'(exp_re_cyc));
      chk("mem_re_addr", re_addr, addr);
    end
    if (exp_we_cyc != 0) begin
      chk("mem_we_cycle", 32'(we_cyc), 32'(exp_we_cyc));
      chk("mem_we_addr", we_addr, addr);
      chk("mem_we_data", we_data, exp_wdata);
    end
    last_rdata = rd;
    last_we_data = we_data;
    txn_no++;
    $display("txn %0d: %s f3=%0d addr=%h wdata=%h -> rdata=%h err=%0b lat=%0d",
             txn_no, we ? "ST" : "LD", f3, addr, wd, rd, last_err, rv_cyc);
  endtask

  initial begin
    logic [7:0] b;
    logic we;
    logic [2:0] f3;
    logic [31:0] a;

    for (int i = 0; i < 1024; i++) begin
      b = 8'($urandom);
      mem[i] = b;
      ref_mem[i] = b;
    end
    mem[256] = 8'hBB; mem[257] = 8'hAA; mem[258] = 8'h99; mem[259] = 8'h88;
    ref_mem[256] = 8'hBB; ref_mem[257] = 8'hAA; ref_mem[258] = 8'h99; ref_mem[259] = 8'h88;

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset_ready", {31'd0, req_ready}, 32'd0);
    chk("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("reset_resp_err", {31'd0, resp_err}, 32'd0);
    chk("reset_resp_rdata", resp_rdata, 32'd0);
    chk("reset_mem_strobes", {30'd0, mem_re, mem_we}, 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    chk("reset_mem_data_in", mem_data_in, 32'd0);
    rst_n = 1'b1;
    #1 chk("ready_after_reset", {31'd0, req_ready}, 32'd1);

    @(negedge clk); do_req(1'b0, 3'd0, 32'h100, 32'd0);
    chk("LB_0x100", last_rdata, 32'hFFFFFFBB);
    @(negedge clk); do_req(1'b0, 3'd4, 32'h101, 32'd0);
    chk("LBU_0x101", last_rdata, 32'h000000AA);
    @(negedge clk); do_req(1'b0, 3'd1, 32'h102, 32'd0);
    chk("LH_0x102", last_rdata, 32'hFFFF8899);
    @(negedge clk); do_req(1'b0, 3'd5, 32'h102, 32'd0);
    chk("LHU_0x102", last_rdata, 32'h00008899);
    @(negedge clk); do_req(1'b1, 3'd0, 32'h100, 32'h12345678);
    chk("SB_merge", last_we_data, 32'h8899AA78);
    @(negedge clk); do_req(1'b0, 3'd2, 32'h100, 32'd0);
    chk("LW_after_SB", last_rdata, 32'h8899AA78);
    @(negedge clk); do_req(1'b1, 3'd2, 32'h200, 32'hDEADBEEF);
    do_req(1'b0, 3'd2, 32'h200, 32'd0);
    chk("LW_back_to_back", last_rdata, 32'hDEADBEEF);
    @(negedge clk); do_req(1'b0, 3'd3, 32'h100, 32'd0);
    chk("illegal_err", {31'd0, last_err}, 32'd1);
    @(negedge clk); do_req(1'b0, 3'd2, 32'h102, 32'd0);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("LW_misaligned_err", {31'd0, last_err}, 32'd1);
`else
    chk("LW_misaligned_low", {16'd0, last_rdata[15:0]}, 32'h00008899);
`endif

    // SH interrupted by reset in its read-wait cycle: nothing may complete.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd1; req_addr = 32'h100; req_wdata = 32'hCAFEF00D;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_test_mem_re", {31'd0, mem_re}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_test_no_we", {31'd0, mem_we}, 32'd0);
    chk("rst_test_no_resp", {31'd0, resp_valid}, 32'd0);
    chk("rst_test_ready_low", {31'd0, req_ready}, 32'd0);
    rst_n = 1'b1;
    #1 chk("rst_test_ready_high", {31'd0, req_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_test_quiet", {30'd0, mem_we, resp_valid}, 32'd0);
    end
    do_req(1'b0, 3'd2, 32'h100, 32'd0);
    chk("LW_after_aborted_SH", last_rdata, 32'h8899AA78);

    for (int n = 0; n < 80; n++) begin
      we = 1'($urandom);
      f3 = 3'($urandom);
      a  = ($urandom_range(0, 1) == 0) ? $urandom_range(32'h300, 32'h33F) : $urandom_range(0, 1019);
      if ($urandom_range(0, 1) == 0) @(negedge clk);
      do_req(we, f3, a, $urandom);
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
